tt_sweep_ctrl: RTL and testbench
================================

Name: tt_sweep_ctrl

Overview:
- Self-test sequencer for a combinational N-input Boolean function unit, for example the 4-input A,B,C,D -> f lab functions.
- On start, drives every input combination 0..2^N-1 in ascending order, waits a settle time, samples f, and assembles the observed truth table.
- Compares the result against an expected minterm mask and reports pass/fail, fail count and the first failing vector.
- Sits between a lab top-level (switches/LEDs or a bench) and the function under test. It replaces hand-written exhaustive stimulus.

Parameters:
- N_IN, 4, number of function inputs; 2^N_IN vectors are swept.
- SETTLE, 1, extra hold cycles per vector before sampling (0..15). Each vector occupies SETTLE+1 cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
- abort  in  1  synchronous cancel of an in-progress sweep
- expected  in  2^N_IN  expected truth table; bit i = f for input vector i; sampled at start
- f_in  in  1  output of the function under test
- vec_out  out  N_IN  applied input vector; MSB = A, LSB = D for N_IN=4
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- valid  out  1  results below belong to a completed sweep
- pass  out  1  observed table equals expected
- truth_table  out  2^N_IN  observed f per vector
- fail_count  out  N_IN+1  number of mismatching vectors (0..2^N_IN)
- first_fail  out  N_IN  lowest mismatching vector index; 0 when none

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - All outputs become 0: vec_out, busy, done, valid, pass, truth_table, fail_count, first_fail.
  - Reset overrides start and abort.
- FSM states: IDLE, HOLD, SAMPLE, FIN.
- IDLE:
  - vec_out=0, busy=0.
  - On start=1:
    - latch expected into exp_q.
    - clear truth_table, fail_count and first_fail; clear valid and pass.
    - load vec=0 and settle_cnt=SETTLE.
    - go to HOLD if SETTLE>0, else go to SAMPLE.
- HOLD:
  - vec_out=vec; decrement settle_cnt.
  - Go to SAMPLE on the cycle settle_cnt reaches 0.
- SAMPLE (1 cycle, vec_out=vec):
  - Write truth_table[vec] <= f_in.
  - If f_in != exp_q[vec]: increment fail_count. If fail_count was 0, set first_fail <= vec.
  - If vec == 2^N_IN-1, go to FIN.
  - Otherwise: vec <= vec+1, settle_cnt <= SETTLE, and go to HOLD (or stay in SAMPLE when SETTLE=0).
- FIN (1 cycle):
  - done=1, valid=1.
  - pass=1 iff fail_count==0.
  - busy=0 and vec_out=0 from this cycle on; next state is IDLE.
- busy is high in HOLD and SAMPLE only.
- Latency: start is sampled at edge k; busy rises after edge k; done is high in the cycle following edge k+2^N_IN*(SETTLE+1). For the defaults, done is high in the 33rd cycle after the start edge.
- Results (truth_table, pass, fail_count, first_fail, valid) hold until the next accepted start.
- start while busy or in FIN is ignored and has no side effects.
- abort in HOLD or SAMPLE:
  - next state IDLE.
  - vec_out=0, busy=0; no done pulse; valid stays 0.
  - partial truth_table and counters are left as-is and are undefined for use.
  - abort in IDLE or FIN is ignored.
- abort and start in the same IDLE cycle: start wins.
- fail_count saturation is impossible by width (max 2^N_IN fits in N_IN+1 bits).
- vec counter wrap: never wraps. The terminal check on 2^N_IN-1 precedes increment.
- f_in is sampled only in SAMPLE. f_in glitches during HOLD are irrelevant.

Decomposition:
- Shared package/header (tt_pkg): FSM state encoding (IDLE=0, HOLD=1, SAMPLE=2, FIN=3), default N_IN and SETTLE constants.
- One natural sub-module: tt_settle_timer, a loadable down-counter with a zero flag, reused by later lab sequencers.
- Mismatch logic, truth-table register and FSM stay in the top module.

Test Plan:
- Bench model f_in = (vec_out in {0,5,10,15}); expected=16'h8421; SETTLE=1; start pulse -> vec_out steps 0..15, each held 2 cycles; done at cycle 33; pass=1, truth_table=16'h8421, fail_count=0, first_fail=0, valid=1.
- Same model with expected=16'h8423 -> pass=0, fail_count=1, first_fail=1, truth_table=16'h8421.
- Model f_in=~(vec_out[3]&vec_out[2]) with expected=16'h0000 -> fail_count=12, first_fail=0; start re-pulsed at cycle 10 is ignored (done still at 33, single pulse).
- abort at the cycle vec_out=7 -> busy=0 and vec_out=0 next cycle; no done pulse; valid=0; a following start completes normally.
- rst_n=0 for one edge mid-sweep at vec_out=9 -> all outputs 0 next cycle, state IDLE; start honoured immediately after.
- SETTLE=0 instance with expected=16'h8421 -> vec_out changes every cycle; done at cycle 17; pass=1.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep sequencers.
// Holds the FSM state encoding and the default sweep geometry.
package tt_pkg;

   localparam int unsigned TT_N_IN    = 4;
   localparam int unsigned TT_SETTLE  = 1;
   localparam int unsigned TT_SETTLE_W = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StHold   = 2'd1,
      StSample = 2'd2,
      StFin    = 2'd3
   } tt_state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag, used to pace vector hold time.
// expire flags the decrement that brings the count to zero.
module tt_settle_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero,
   output logic             expire
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero   = (count_q == '0);
   assign expire = dec && (count_q == WIDTH'(1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive self-test sequencer: sweeps all input vectors of a Boolean unit,
// records the observed truth table and compares it against an expected mask.
module tt_sweep_ctrl
   import tt_pkg::*;
#(
   parameter int unsigned N_IN   = TT_N_IN,
   parameter int unsigned SETTLE = TT_SETTLE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [(1<<N_IN)-1:0]   expected,
   input  logic                   f_in,
   output logic [N_IN-1:0]        vec_out,
   output logic                   busy,
   output logic                   done,
   output logic                   valid,
   output logic                   pass,
   output logic [(1<<N_IN)-1:0]   truth_table,
   output logic [N_IN:0]          fail_count,
   output logic [N_IN-1:0]        first_fail
);

   localparam int unsigned NVEC = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = '1;
   localparam logic [TT_SETTLE_W-1:0] SETTLE_LD = TT_SETTLE_W'(SETTLE);
   localparam tt_state_e AFTER_LOAD = (SETTLE > 0) ? StHold : StSample;

   tt_state_e         state_q;
   logic [N_IN-1:0]   vec_q;
   logic              busy_q;
   logic              done_q;
   logic              valid_q;
   logic              pass_q;
   logic [NVEC-1:0]   exp_q;
   logic [NVEC-1:0]   tt_q;
   logic [N_IN:0]     fail_q;
   logic [N_IN-1:0]   first_q;

   logic timer_load;
   logic timer_dec;
   logic timer_zero;
   logic timer_expire;
   logic mismatch;

   always_comb begin
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      unique case (state_q)
         StIdle:   timer_load = start;
         StHold:   timer_dec  = !abort;
         StSample: timer_load = !abort && (vec_q != LAST_VEC);
         default:  ;
      endcase
   end

   assign mismatch = (state_q == StSample) && (f_in != exp_q[vec_q]);

   tt_settle_timer #(
      .WIDTH (TT_SETTLE_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (SETTLE_LD),
      .dec      (timer_dec),
      .zero     (timer_zero),
      .expire   (timer_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
         exp_q   <= '0;
         tt_q    <= '0;
         fail_q  <= '0;
         first_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // start beats a simultaneous abort here since abort is not looked at
               if (start) begin
                  exp_q   <= expected;
                  tt_q    <= '0;
                  fail_q  <= '0;
                  first_q <= '0;
                  valid_q <= 1'b0;
                  pass_q  <= 1'b0;
                  vec_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= AFTER_LOAD;
               end
            end
            StHold: begin
               if (abort) begin
                  state_q <= StIdle;
                  vec_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (timer_expire || timer_zero) begin
                  state_q <= StSample;
               end
            end
            StSample: begin
               if (abort) begin
                  state_q <= StIdle;
                  vec_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  tt_q[vec_q] <= f_in;
                  if (mismatch) begin
                     fail_q <= fail_q + 1'b1;
                     if (fail_q == '0) first_q <= vec_q;
                  end
                  // Terminal check precedes the increment so vec never wraps
                  if (vec_q == LAST_VEC) begin
                     state_q <= StFin;
                     vec_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     valid_q <= 1'b1;
                     pass_q  <= (fail_q == '0) && !mismatch;
                  end else begin
                     vec_q   <= vec_q + 1'b1;
                     state_q <= AFTER_LOAD;
                  end
               end
            end
            StFin: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign vec_out     = vec_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign valid       = valid_q;
   assign pass        = pass_q;
   assign truth_table = tt_q;
   assign fail_count  = fail_q;
   assign first_fail  = first_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) driven by a
// behavioural function model, with results predicted from whole-table arithmetic.
module tb_tt_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_s    [2];
   logic        abort_s    [2];
   logic [15:0] expected_s [2];
   logic        f_s        [2];
   logic [3:0]  vec_a      [2];
   logic        busy_a     [2];
   logic        done_a     [2];
   logic        valid_a    [2];
   logic        pass_a     [2];
   logic [15:0] tt_a       [2];
   logic [4:0]  fc_a       [2];
   logic [3:0]  ff_a       [2];

   int          mode;
   logic [15:0] rand_tbl;
   int          errors = 0;
   int          checks = 0;

   // Function under test: 0 = diagonal minterms, 1 = NAND(A,B), else random table
   function automatic logic fmodel(input int m, input logic [3:0] v, input logic [15:0] r);
      case (m)
         0:       return (v == 4'd0) || (v == 4'd5) || (v == 4'd10) || (v == 4'd15);
         1:       return !(v[3] && v[2]);
         default: return r[v];
      endcase
   endfunction

   function automatic logic [15:0] model_tt(input int m, input logic [15:0] r);
      logic [15:0] t;
      for (int v = 0; v < 16; v++) t[v] = fmodel(m, 4'(v), r);
      return t;
   endfunction

   assign f_s[0] = fmodel(mode, vec_a[0], rand_tbl);
   assign f_s[1] = fmodel(mode, vec_a[1], rand_tbl);

   tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut_s1 (
      .clk (clk), .rst_n (rst_n), .start (start_s[0]), .abort (abort_s[0]),
      .expected (expected_s[0]), .f_in (f_s[0]), .vec_out (vec_a[0]),
      .busy (busy_a[0]), .done (done_a[0]), .valid (valid_a[0]), .pass (pass_a[0]),
      .truth_table (tt_a[0]), .fail_count (fc_a[0]), .first_fail (ff_a[0])
   );

   tt_sweep_ctrl #(.N_IN(4), .SETTLE(0)) dut_s0 (
      .clk (clk), .rst_n (rst_n), .start (start_s[1]), .abort (abort_s[1]),
      .expected (expected_s[1]), .f_in (f_s[1]), .vec_out (vec_a[1]),
      .busy (busy_a[1]), .done (done_a[1]), .valid (valid_a[1]), .pass (pass_a[1]),
      .truth_table (tt_a[1]), .fail_count (fc_a[1]), .first_fail (ff_a[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full sweep on instance sel; optional re-start at cycle 10 and abort with start
   task automatic run_sweep(input int sel, input logic [15:0] exp, input bit restart,
                            input bit abort_with_start);
      int          per;
      int          done_at;
      int          cyc;
      int          vec_err;
      int          busy_err;
      int          nfail;
      int          ff;
      logic [15:0] mt;
      logic [15:0] x;
      per     = (sel == 0) ? 2 : 1;
      done_at = 16 * per + 1;
      mt      = model_tt(mode, rand_tbl);
      x       = mt ^ exp;
      nfail   = $countones(x);
      ff      = 0;
      for (int i = 15; i >= 0; i--) if (x[i]) ff = i;

      expected_s[sel] = exp;
      start_s[sel]    = 1'b1;
      abort_s[sel]    = abort_with_start;
      step();
      start_s[sel] = 1'b0;
      abort_s[sel] = 1'b0;
      cyc      = 1;
      vec_err  = 0;
      busy_err = 0;
      while (done_a[sel] !== 1'b1 && cyc < 100) begin
         if (vec_a[sel] !== 4'((cyc - 1) / per)) vec_err++;
         if (busy_a[sel] !== 1'b1) busy_err++;
         start_s[sel] = restart && (cyc == 10);
         if (restart && cyc == 10) expected_s[sel] = ~exp;
         step();
         cyc++;
      end
      start_s[sel] = 1'b0;
      check("done_cycle", cyc, done_at);
      check("vec_sequence_errs", vec_err, 0);
      check("busy_during_sweep_errs", busy_err, 0);
      check("valid_at_done", valid_a[sel], 1'b1);
      check("pass", pass_a[sel], (mt == exp));
      check("truth_table", tt_a[sel], mt);
      check("fail_count", fc_a[sel], nfail);
      check("first_fail", ff_a[sel], ff);
      check("busy_at_done", busy_a[sel], 1'b0);
      check("vec_out_at_done", vec_a[sel], 4'd0);
      // abort during FIN must be ignored
      abort_s[sel] = 1'b1;
      step();
      abort_s[sel] = 1'b0;
      check("done_single_pulse", done_a[sel], 1'b0);
      check("valid_holds", valid_a[sel], 1'b1);
      check("pass_holds", pass_a[sel], (mt == exp));
      check("tt_holds", tt_a[sel], mt);
   endtask

   initial begin
      int n;
      int dones;
      for (int i = 0; i < 2; i++) begin
         start_s[i]    = 1'b0;
         abort_s[i]    = 1'b0;
         expected_s[i] = '0;
      end
      mode     = 0;
      rand_tbl = '0;
      rst_n    = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 2; i++) begin
         check("rst_vec_out", vec_a[i], 4'd0);
         check("rst_busy", busy_a[i], 1'b0);
         check("rst_done", done_a[i], 1'b0);
         check("rst_valid", valid_a[i], 1'b0);
         check("rst_pass", pass_a[i], 1'b0);
         check("rst_tt", tt_a[i], 16'h0);
         check("rst_fail_count", fc_a[i], 5'd0);
         check("rst_first_fail", ff_a[i], 4'd0);
      end
      rst_n = 1'b1;
      step();

      mode = 0;
      run_sweep(0, 16'h8421, 1'b0, 1'b0);
      run_sweep(0, 16'h8423, 1'b0, 1'b0);
      mode = 1;
      run_sweep(0, 16'h0000, 1'b1, 1'b0);

      // Abort mid-sweep at vector 7
      mode = 0;
      expected_s[0] = 16'h8421;
      start_s[0]    = 1'b1;
      step();
      start_s[0] = 1'b0;
      n = 0;
      while (vec_a[0] !== 4'd7 && n < 100) begin
         step();
         n++;
      end
      check("abort_reach_vec7", vec_a[0], 4'd7);
      abort_s[0] = 1'b1;
      step();
      abort_s[0] = 1'b0;
      check("abort_busy", busy_a[0], 1'b0);
      check("abort_vec_out", vec_a[0], 4'd0);
      check("abort_valid", valid_a[0], 1'b0);
      dones = 0;
      repeat (40) begin
         if (done_a[0] === 1'b1) dones++;
         step();
      end
      check("abort_no_done", dones, 0);
      check("abort_stays_idle", busy_a[0], 1'b0);
      run_sweep(0, 16'h8421, 1'b0, 1'b0);

      // Reset mid-sweep at vector 9, with start held during the reset edge
      expected_s[0] = 16'h8421;
      start_s[0]    = 1'b1;
      step();
      start_s[0] = 1'b0;
      n = 0;
      while (vec_a[0] !== 4'd9 && n < 100) begin
         step();
         n++;
      end
      check("reset_reach_vec9", vec_a[0], 4'd9);
      rst_n      = 1'b0;
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      rst_n      = 1'b1;
      check("mid_rst_vec_out", vec_a[0], 4'd0);
      check("mid_rst_busy", busy_a[0], 1'b0);
      check("mid_rst_done", done_a[0], 1'b0);
      check("mid_rst_valid", valid_a[0], 1'b0);
      check("mid_rst_pass", pass_a[0], 1'b0);
      check("mid_rst_tt", tt_a[0], 16'h0);
      check("mid_rst_fail_count", fc_a[0], 5'd0);
      check("mid_rst_first_fail", ff_a[0], 4'd0);
      run_sweep(0, 16'h8421, 1'b0, 1'b0);

      // SETTLE=0 instance, with abort asserted alongside start
      mode = 0;
      run_sweep(1, 16'h8421, 1'b0, 1'b1);

      // Random functions against random or matching expectations
      mode = 2;
      for (int i = 0; i < 6; i++) begin
         logic [15:0] e;
         rand_tbl = 16'($urandom);
         e = ($urandom_range(0, 1) == 0) ? rand_tbl : 16'($urandom);
         run_sweep(i % 2, e, 1'b0, (i == 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
